// File: rtl/fir_pkg.sv
// Shared FIR datapath types and defaults.
// Used by the filter and its downstream stages.
package fir_pkg;
   localparam int DATA_W_DEFAULT = 16;
   typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;
endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Level-based full/empty; push while full only lands alongside a pop.
module sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         unique case (1'b1)
            do_push & ~do_pop: level <= level + 1'b1;
            do_pop & ~do_push: level <= level - 1'b1;
            default:           level <= level;
         endcase
      end
   end

endmodule

// File: rtl/fir_decim_fifo.sv
// FIR output stage: keep every DECIM-th sample, buffer, stream out.
// Kept samples arriving while full are dropped and flagged sticky.
module fir_decim_fifo
   import fir_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int DECIM  = 4,
   parameter int DEPTH  = 8,
   localparam int LW = $clog2(DEPTH) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic signed [DATA_W-1:0] in_data,
   input  logic                     phase_clr,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] out_data,
   output logic [LW-1:0]            level,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam logic [PW-1:0] LAST = PW'(DECIM - 1);

   logic [PW-1:0] phase;
   logic [PW-1:0] eff;
   logic          keep;
   logic          pop;
   logic          full;
   logic          empty;
   logic          drop;

   assign eff       = phase_clr ? '0 : phase;
   assign keep      = in_valid & (eff == '0);
   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   assign drop      = keep & full & ~pop;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase    <= '0;
         overflow <= 1'b0;
      end else begin
         if (in_valid)
            phase <= (eff == LAST) ? '0 : eff + 1'b1;
         else if (phase_clr)
            phase <= '0;
         // a drop in the clearing cycle must stay visible
         if (drop)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
      end
   end

   sample_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (keep),
      .pop   (pop),
      .din   (in_data),
      .dout  (out_data),
      .level (level),
      .full  (full),
      .empty (empty)
   );

endmodule
